// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32 execute stage: ALU codes, opcode and
// funct fields for RV32M, mul/div FSM state and captured mul/div control.
package riscv_pkg;

    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd10;

    localparam logic [6:0] OP_R          = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Control captured at the start of a mul/div operation.
    typedef struct packed {
        logic [2:0] func3;
        logic       neg_q;   // negate product / quotient at the end
        logic       neg_r;   // negate remainder at the end
        logic       div0;    // divisor was zero
    } md_ctrl_t;

    function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] func7);
        return (opcode == OP_R) && (func7 == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, sign applied when the result is read in DONE.
module muldiv_iter
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MD_CYCLES = 32
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [2:0]      i_func3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

    md_state_t        r_state;
    md_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_hi;       // product high half / partial remainder
    logic [XLEN-1:0]  r_lo;       // multiplier / quotient being built
    logic [XLEN-1:0]  r_b;        // multiplicand / divisor magnitude
    logic [XLEN-1:0]  r_a_orig;   // raw dividend, the remainder on divide-by-zero
    md_ctrl_t         r_ctrl;

    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_shift;
    logic            w_div_ge;
    logic [XLEN-1:0] w_div_sub;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    // Operand signedness and magnitudes for the requested operation.
    assign w_a_signed = (i_func3 == F3_MULH) || (i_func3 == F3_MULHSU) ||
                        (i_func3 == F3_DIV)  || (i_func3 == F3_REM);
    assign w_b_signed = (i_func3 == F3_MULH) || (i_func3 == F3_DIV) || (i_func3 == F3_REM);
    assign w_neg_a    = w_a_signed && i_a[XLEN-1];
    assign w_neg_b    = w_b_signed && i_b[XLEN-1];
    assign w_mag_a    = w_neg_a ? (~i_a + 1'b1) : i_a;
    assign w_mag_b    = w_neg_b ? (~i_b + 1'b1) : i_b;

    // One multiply step: add multiplicand on LSB, shift the 2*XLEN pair right.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    // One divide step: shift next dividend bit into the remainder, trial-subtract.
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_sub   = XLEN'(w_div_shift - {1'b0, r_b});

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MD_IDLE: if (i_start) w_state_next = MD_BUSY;
            MD_BUSY: if (r_cnt == CNT_LAST) w_state_next = MD_DONE;
            MD_DONE: w_state_next = MD_IDLE;
            default: w_state_next = MD_IDLE;
        endcase
    end

    // FSM outputs; busy covers the start cycle so upstream freezes immediately.
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            MD_IDLE: o_busy = i_start;
            MD_BUSY: o_busy = 1'b1;
            MD_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture and per-cycle iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_a_orig <= '0;
            r_ctrl   <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_cnt        <= '0;
                        r_hi         <= '0;
                        r_a_orig     <= i_a;
                        r_ctrl.func3 <= i_func3;
                        r_ctrl.neg_q <= w_neg_a ^ w_neg_b;
                        r_ctrl.neg_r <= w_neg_a;
                        r_ctrl.div0  <= (i_b == '0);
                        if (i_func3[2]) begin
                            r_lo <= w_mag_a;
                            r_b  <= w_mag_b;
                        end else begin
                            r_lo <= w_mag_b;
                            r_b  <= w_mag_a;
                        end
                    end
                end
                MD_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_ctrl.func3[2]) begin
                        r_hi <= w_div_ge ? w_div_sub : w_div_shift[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_div_ge};
                    end else begin
                        r_hi <= w_mul_sum[XLEN:1];
                        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Sign fix-up and special divide cases; overflow falls out of the magnitude path.
    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_ctrl.neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_fix  = r_ctrl.div0 ? '1 : (r_ctrl.neg_q ? (~r_lo + 1'b1) : r_lo);
    assign w_rem_fix  = r_ctrl.div0 ? r_a_orig : (r_ctrl.neg_r ? (~r_hi + 1'b1) : r_hi);

    // Result select by captured func3.
    always_comb begin
        o_result = w_rem_fix;
        case (r_ctrl.func3)
            F3_MUL:                       o_result = w_prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: o_result = w_prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              o_result = w_quo_fix;
            default:                      o_result = w_rem_fix;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: operand forwarding, ALU, branch/jump resolution and an
// optional iterative RV32M unit that stalls upstream while it runs.
// Build option: define RV32M_EN to include the mul/div unit; without it M
// encodings execute as the ALU op on alu_op_in and stall_out is tied low.
module ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MD_CYCLES = 32
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [XLEN-1:0] rout1_in,
    input  logic [XLEN-1:0] rout2_in,
    input  logic [4:0]      rs1_in,
    input  logic [4:0]      rs2_in,
    input  logic [4:0]      rd_in,
    input  logic [3:0]      alu_op_in,
    input  logic [2:0]      func3_in,
    input  logic [6:0]      func7_in,
    input  logic [6:0]      opcode_in,
    input  logic            aluSrc_in,
    input  logic            regWE_in,
    input  logic            beq_in,
    input  logic            bneq_in,
    input  logic            bge_in,
    input  logic            blt_in,
    input  logic            jmp_in,
    input  logic            jalr_in,
    input  logic            exmem_regWE_in,
    input  logic            memwb_regWE_in,
    input  logic [4:0]      exmem_rd_in,
    input  logic [4:0]      memwb_rd_in,
    input  logic [XLEN-1:0] exmem_result_in,
    input  logic [XLEN-1:0] memwb_data_in,
    output logic [XLEN-1:0] result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic            regWE_out,
    output logic            redirect_out,
    output logic [XLEN-1:0] target_out,
    output logic            stall_out
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    logic [XLEN-1:0]    w_op_a;
    logic [XLEN-1:0]    w_fwd_b;
    logic [XLEN-1:0]    w_op_b;
    logic [XLEN-1:0]    w_alu_res;
    logic [XLEN-1:0]    w_br_target;
    logic [XLEN-1:0]    w_jalr_sum;
    logic [XLEN-1:0]    w_link;
    logic [XLEN-1:0]    w_md_result;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_eq;
    logic               w_lt;
    logic               w_ltu;
    logic               w_taken;
    logic               w_jump;
    logic               w_stall;
    logic               w_md_done;

    // Forward rs1: EX/MEM has priority over MEM/WB, x0 never forwards.
    always_comb begin
        w_op_a = rout1_in;
        if (memwb_regWE_in && (memwb_rd_in != 5'd0) && (memwb_rd_in == rs1_in)) w_op_a = memwb_data_in;
        if (exmem_regWE_in && (exmem_rd_in != 5'd0) && (exmem_rd_in == rs1_in)) w_op_a = exmem_result_in;
    end

    // Forward rs2 with the same priority.
    always_comb begin
        w_fwd_b = rout2_in;
        if (memwb_regWE_in && (memwb_rd_in != 5'd0) && (memwb_rd_in == rs2_in)) w_fwd_b = memwb_data_in;
        if (exmem_regWE_in && (exmem_rd_in != 5'd0) && (exmem_rd_in == rs2_in)) w_fwd_b = exmem_result_in;
    end

    assign w_op_b  = aluSrc_in ? imm_in : w_fwd_b;
    assign w_shamt = w_op_b[SHAMT_W-1:0];
    assign w_eq    = (w_op_a == w_op_b);
    assign w_lt    = ($signed(w_op_a) < $signed(w_op_b));
    assign w_ltu   = (w_op_a < w_op_b);

    // ALU.
    always_comb begin
        w_alu_res = '0;
        case (alu_op_in)
            ALU_ADD:   w_alu_res = w_op_a + w_op_b;
            ALU_SUB:   w_alu_res = w_op_a - w_op_b;
            ALU_AND:   w_alu_res = w_op_a & w_op_b;
            ALU_OR:    w_alu_res = w_op_a | w_op_b;
            ALU_XOR:   w_alu_res = w_op_a ^ w_op_b;
            ALU_SLL:   w_alu_res = w_op_a << w_shamt;
            ALU_SRL:   w_alu_res = w_op_a >> w_shamt;
            ALU_SRA:   w_alu_res = XLEN'($signed(w_op_a) >>> w_shamt);
            ALU_SLT:   w_alu_res = XLEN'(w_lt);
            ALU_SLTU:  w_alu_res = XLEN'(w_ltu);
            ALU_PASSB: w_alu_res = w_op_b;
            default:   w_alu_res = '0;
        endcase
    end

    // Branch and jump resolution.
    assign w_taken     = (beq_in && w_eq) || (bneq_in && !w_eq) ||
                         (blt_in && w_lt) || (bge_in && !w_lt);
    assign w_jump      = jmp_in || jalr_in;
    assign w_br_target = pc_in + imm_in;
    assign w_jalr_sum  = w_op_a + imm_in;
    assign w_link      = pc_in + XLEN'(4);

`ifdef RV32M_EN
    logic w_is_m;
    logic w_unused;

    assign w_is_m   = is_muldiv(opcode_in, func7_in);
    assign w_unused = ^rd_in;

    muldiv_iter #(
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_is_m),
        .i_func3  (func3_in),
        .i_a      (w_op_a),
        .i_b      (w_fwd_b),
        .o_busy   (w_stall),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );
`else
    logic w_unused;

    assign w_stall     = 1'b0;
    assign w_md_done   = 1'b0;
    assign w_md_result = '0;
    assign w_unused    = ^{clk, rst, rd_in, func3_in, func7_in, opcode_in, 32'(MD_CYCLES)};
`endif

    // Stage outputs toward EX/MEM and the front end.
    always_comb begin
        if (w_md_done)   result_out = w_md_result;
        else if (w_jump) result_out = w_link;
        else             result_out = w_alu_res;
        store_data_out = w_fwd_b;
        regWE_out      = regWE_in && !w_stall;
        redirect_out   = (w_taken || w_jump) && !w_stall;
        target_out     = jalr_in ? (w_jalr_sum & ~XLEN'(1)) : w_br_target;
        stall_out      = w_stall;
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed forwarding/branch/jump cases,
// random single-cycle ops against a behavioural model, and RV32M operations
// (when RV32M_EN is defined) including reset in the middle of an operation.
module tb_ex_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in, imm_in, rout1_in, rout2_in;
    logic [4:0]  rs1_in, rs2_in, rd_in;
    logic [3:0]  alu_op_in;
    logic [2:0]  func3_in;
    logic [6:0]  func7_in, opcode_in;
    logic        aluSrc_in, regWE_in, beq_in, bneq_in, bge_in, blt_in, jmp_in, jalr_in;
    logic        exmem_regWE_in, memwb_regWE_in;
    logic [4:0]  exmem_rd_in, memwb_rd_in;
    logic [31:0] exmem_result_in, memwb_data_in;
    logic [31:0] result_out, store_data_out, target_out;
    logic        regWE_out, redirect_out, stall_out;

    int n_total;
    int n_bad;

    ex_stage #(.XLEN(32), .MD_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .pc_in(pc_in), .imm_in(imm_in), .rout1_in(rout1_in), .rout2_in(rout2_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
        .alu_op_in(alu_op_in), .func3_in(func3_in), .func7_in(func7_in), .opcode_in(opcode_in),
        .aluSrc_in(aluSrc_in), .regWE_in(regWE_in), .beq_in(beq_in), .bneq_in(bneq_in),
        .bge_in(bge_in), .blt_in(blt_in), .jmp_in(jmp_in), .jalr_in(jalr_in),
        .exmem_regWE_in(exmem_regWE_in), .memwb_regWE_in(memwb_regWE_in),
        .exmem_rd_in(exmem_rd_in), .memwb_rd_in(memwb_rd_in),
        .exmem_result_in(exmem_result_in), .memwb_data_in(memwb_data_in),
        .result_out(result_out), .store_data_out(store_data_out), .regWE_out(regWE_out),
        .redirect_out(redirect_out), .target_out(target_out), .stall_out(stall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_nop();
        pc_in = '0; imm_in = '0; rout1_in = '0; rout2_in = '0;
        rs1_in = '0; rs2_in = '0; rd_in = '0; alu_op_in = ALU_ADD;
        func3_in = '0; func7_in = '0; opcode_in = '0;
        aluSrc_in = 0; regWE_in = 0; beq_in = 0; bneq_in = 0; bge_in = 0; blt_in = 0;
        jmp_in = 0; jalr_in = 0;
        exmem_regWE_in = 0; memwb_regWE_in = 0; exmem_rd_in = '0; memwb_rd_in = '0;
        exmem_result_in = '0; memwb_data_in = '0;
    endtask

    // Value a source register sees after the forwarding rules.
    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (exmem_regWE_in && exmem_rd_in != 0 && exmem_rd_in == rs) return exmem_result_in;
        if (memwb_regWE_in && memwb_rd_in != 0 && memwb_rd_in == rs) return memwb_data_in;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        int sh;
        sa = a;
        sh = int'(b % 32);
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLL:   return a << sh;
            ALU_SRL:   return a >> sh;
            ALU_SRA:   return sa >>> sh;
            ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_PASSB: return b;
            default:   return 32'd0;
        endcase
    endfunction

    // RV32M reference using 64-bit integer arithmetic.
    function automatic logic [31:0] m_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            F3_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
            F3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            F3_MULHSU: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
            F3_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic rand_op();
        int kind;
        set_nop();
        pc_in = $urandom & 32'hFFFF_FFFC;
        imm_in = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
        rout1_in = $urandom; rout2_in = $urandom;
        rs1_in = 5'($urandom_range(0, 3)); rs2_in = 5'($urandom_range(0, 3));
        rd_in = 5'($urandom);
        alu_op_in = 4'($urandom_range(0, 10));
        func3_in = 3'($urandom); func7_in = 7'($urandom); opcode_in = 7'($urandom);
        aluSrc_in = 1'($urandom); regWE_in = 1'($urandom);
        exmem_regWE_in = 1'($urandom); memwb_regWE_in = 1'($urandom);
        exmem_rd_in = 5'($urandom_range(0, 3)); memwb_rd_in = 5'($urandom_range(0, 3));
        exmem_result_in = $urandom; memwb_data_in = $urandom;
        if ($urandom_range(0, 3) == 0) rout2_in = rout1_in;
        kind = $urandom_range(0, 6);
        case (kind)
            1: beq_in = 1;
            2: bneq_in = 1;
            3: blt_in = 1;
            4: bge_in = 1;
            5: jmp_in = 1;
            6: jalr_in = 1;
            default: ;
        endcase
`ifdef RV32M_EN
        if (opcode_in == OP_R && func7_in == FUNCT7_MULDIV) func7_in = 7'h20;
`else
        if ($urandom_range(0, 3) == 0) begin
            opcode_in = OP_R;
            func7_in  = FUNCT7_MULDIV;
        end
`endif
    endtask

    task automatic check_comb();
        logic [31:0] a, b, ob, exp_res;
        logic taken, jmp_any;
        a = fwd(rs1_in, rout1_in);
        b = fwd(rs2_in, rout2_in);
        ob = aluSrc_in ? imm_in : b;
        taken = (beq_in && a == ob) || (bneq_in && a != ob) ||
                (blt_in && $signed(a) < $signed(ob)) || (bge_in && !($signed(a) < $signed(ob)));
        jmp_any = jmp_in || jalr_in;
        exp_res = jmp_any ? pc_in + 32'd4 : alu_ref(alu_op_in, a, ob);
        check("result", result_out, exp_res);
        check("store", store_data_out, b);
        check("regwe", 32'(regWE_out), 32'(regWE_in));
        check("stall", 32'(stall_out), 32'd0);
        check("redirect", 32'(redirect_out), 32'(taken || jmp_any));
        if (taken || jmp_any)
            check("target", target_out, jalr_in ? ((a + imm_in) & ~32'h1) : pc_in + imm_in);
    endtask

    task automatic set_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        set_nop();
        opcode_in = OP_R; func7_in = FUNCT7_MULDIV; func3_in = f3;
        rs1_in = 5'd1; rs2_in = 5'd2; rd_in = 5'd3;
        rout1_in = a; rout2_in = b; regWE_in = 1;
    endtask

    task automatic run_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        logic [31:0] exp;
        exp = m_ref(f3, a, b);
        @(posedge clk); #1;
        set_m(f3, a, b);
        @(negedge clk);
        check("m_stall_first", 32'(stall_out), 32'd1);
        check("m_we_first", 32'(regWE_out), 32'd0);
        cyc = 1;
        while (cyc < 100) begin
            @(negedge clk);
            if (!stall_out) break;
            check("m_we_stall", 32'(regWE_out), 32'd0);
            check("m_redir_stall", 32'(redirect_out), 32'd0);
            cyc++;
        end
        check("m_stall_len", 32'(cyc), 32'd33);
        check("m_result", result_out, exp);
        check("m_we_done", 32'(regWE_out), 32'd1);
    endtask

    logic [31:0] specials [4];

    function automatic logic [31:0] pick_val();
        int s;
        s = $urandom_range(0, 7);
        if (s < 4) return specials[s];
        return $urandom;
    endfunction

    initial begin
        n_total = 0;
        n_bad   = 0;
        specials[0] = 32'h0;
        specials[1] = 32'h1;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        rst = 1;
        set_nop();
        regWE_in = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_we", 32'(regWE_out), 32'd1);
        check("rst_redirect", 32'(redirect_out), 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // Forwarding priority, observed through A + imm(0).
        set_nop();
        aluSrc_in = 1; rs1_in = 5'd5; rs2_in = 5'd5; rout1_in = 32'h33; rout2_in = 32'h44;
        exmem_regWE_in = 1; exmem_rd_in = 5'd5; exmem_result_in = 32'h11;
        memwb_regWE_in = 1; memwb_rd_in = 5'd5; memwb_data_in = 32'h22;
        @(negedge clk);
        check("fwd_exmem", result_out, 32'h11);
        check("fwd_exmem_b", store_data_out, 32'h11);
        @(posedge clk); #1;
        exmem_regWE_in = 0;
        @(negedge clk);
        check("fwd_memwb", result_out, 32'h22);
        @(posedge clk); #1;
        exmem_regWE_in = 1; rs1_in = 5'd0; exmem_rd_in = 5'd0; memwb_rd_in = 5'd0;
        @(negedge clk);
        check("fwd_x0", result_out, 32'h33);

        // Signed branch compare.
        @(posedge clk); #1;
        set_nop();
        rs1_in = 5'd1; rs2_in = 5'd2; rout1_in = 32'hFFFF_FFFF; rout2_in = 32'h1;
        pc_in = 32'h100; imm_in = 32'h20; blt_in = 1;
        @(negedge clk);
        check("blt_redirect", 32'(redirect_out), 32'd1);
        check("blt_target", target_out, 32'h120);
        @(posedge clk); #1;
        blt_in = 0; bge_in = 1;
        @(negedge clk);
        check("bge_redirect", 32'(redirect_out), 32'd0);

        // jalr clears bit 0 and links pc+4.
        @(posedge clk); #1;
        set_nop();
        rs1_in = 5'd1; rout1_in = 32'h203; imm_in = 32'h4; pc_in = 32'h40; jalr_in = 1;
        @(negedge clk);
        check("jalr_target", target_out, 32'h206);
        check("jalr_link", result_out, 32'h44);
        check("jalr_redirect", 32'(redirect_out), 32'd1);

        // Random single-cycle instructions.
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            rand_op();
            @(negedge clk);
            check_comb();
        end

`ifdef RV32M_EN
        run_m(F3_DIV,   32'hFFFF_FFF9, 32'd2);
        run_m(F3_REM,   32'hFFFF_FFF9, 32'd2);
        run_m(F3_DIVU,  32'd5,         32'd0);
        run_m(F3_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_m(F3_REM,   32'h8000_0000, 32'hFFFF_FFFF);
        run_m(F3_MULH,  32'h8000_0000, 32'h8000_0000);
        run_m(F3_MULHU, 32'hFFFF_FFFF, 32'd2);
        run_m(F3_MUL,   32'hFFFF_FFFD, 32'd7);

        // Reset at BUSY iteration 10 abandons the operation.
        @(posedge clk); #1;
        set_m(F3_DIV, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        #1;
        check("rst_mid_busy", 32'(stall_out), 32'd1);
        rst = 1;
        set_nop();
        @(posedge clk); #1;
        rst = 0;
        check("rst_mid_stall", 32'(stall_out), 32'd0);
        run_m(F3_DIV, 32'd100, 32'd7);

        for (int i = 0; i < 8; i++) begin
            run_m(3'($urandom_range(0, 7)), pick_val(), pick_val());
        end
`else
        // Without the M unit an M encoding is an ordinary ALU op.
        @(posedge clk); #1;
        set_m(F3_DIV, 32'd7, 32'd2);
        alu_op_in = ALU_SUB;
        @(negedge clk);
        check("m_as_alu_stall", 32'(stall_out), 32'd0);
        check("m_as_alu_result", result_out, 32'd5);
        check("m_as_alu_we", 32'(regWE_out), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
